// File: rtl/xgmii_tx_frame_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// xgmii_tx_frame_arbiter: round-robin whole-frame scheduler of two retransmit
// FIFOs onto one XGMII32 TX port, with DIC inter-packet gap and gearbox ena slot.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
package xgmii_tx_frame_arbiter_pkg;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ctrl;
        logic        ena;
    } xgmii32_t;
endpackage

module xgmii_tx_frame_arbiter
    import xgmii_tx_frame_arbiter_pkg::*;
#(
    parameter int ENA_PERIOD     = 33,
    parameter int MIN_IDLE_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] src0_q,
    input  logic        src0_empty,
    input  logic        src0_frame_rdy,
    output logic        src0_rdreq,
    input  logic [39:0] src1_q,
    input  logic        src1_empty,
    input  logic        src1_frame_rdy,
    output logic        src1_rdreq,
    output xgmii32_t    tx,
    output logic [1:0]  grant,
    output logic        err_underrun,
    output logic        err_nostart,
    input  logic        clr_err
);

    localparam int          c_CNT_W     = (ENA_PERIOD > 1) ? $clog2(ENA_PERIOD) : 1;
    localparam int          c_IDLE_W    = $clog2(MIN_IDLE_WORDS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ENA_PERIOD - 1);
    localparam logic [31:0] c_IDLE_DATA = 32'h07070707;
    localparam logic [31:0] c_ERR_DATA  = 32'hFEFEFEFE;

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_SEND = 2'd1;
    localparam logic [1:0]  c_IPG  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_ena_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [c_IDLE_W-1:0] w_idle_nxt;
    logic [1:0]          r_dic;
    logic [1:0]          w_dic_nxt;
    logic                r_prio1;
    logic                w_prio_nxt;
    logic                r_owner;
    logic                w_owner_nxt;
    logic [1:0]          r_grant;
    logic [1:0]          w_grant_nxt;
    logic                r_err_underrun;
    logic                r_err_nostart;
    xgmii32_t            r_tx;

    logic                w_slot;
    logic                w_req0;
    logic                w_req1;
    logic                w_any_req;
    logic                w_win1;
    logic [35:0]         w_gnt_q;
    logic [38:0]         w_own_q;
    logic                w_own_empty;
    logic                w_is_start;
    logic [2:0]          w_dic_sum;
    logic                w_pop0;
    logic                w_pop1;
    logic [31:0]         w_tx_data;
    logic [3:0]          w_tx_ctrl;
    logic                w_set_under;
    logic                w_set_nostart;
    logic                w_unused;

    assign w_unused = &{1'b0, src0_q[39], src1_q[39]};

    // The last count of each period is the gearbox slot: everything freezes.
    assign w_slot      = (r_ena_cnt == c_CNT_LAST);
    assign w_req0      = src0_frame_rdy & ~src0_empty;
    assign w_req1      = src1_frame_rdy & ~src1_empty;
    assign w_any_req   = w_req0 | w_req1;
    assign w_win1      = w_req1 & (~w_req0 | r_prio1);
    assign w_gnt_q     = w_win1 ? src1_q[35:0] : src0_q[35:0];
    assign w_own_q     = r_owner ? src1_q[38:0] : src0_q[38:0];
    assign w_own_empty = r_owner ? src1_empty : src0_empty;
    assign w_is_start  = (w_gnt_q[35:32] == 4'b0001) && (w_gnt_q[7:0] == 8'hFB);
    assign w_dic_sum   = {1'b0, r_dic} + {1'b0, w_own_q[38:37]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_dic_nxt   = r_dic;
        w_prio_nxt  = r_prio1;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
        if (!w_slot) begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        w_prio_nxt = ~w_win1;
                        if (w_is_start) begin
                            w_state_nxt = c_SEND;
                            w_owner_nxt = w_win1;
                            w_grant_nxt = w_win1 ? 2'b10 : 2'b01;
                        end
                    end
                end
                c_SEND: begin
                    if (!w_own_empty && w_own_q[36]) begin
                        w_state_nxt = c_IPG;
                        w_grant_nxt = 2'b00;
                        // Either branch leaves the sum modulo 4 as the new deficit.
                        w_dic_nxt   = w_dic_sum[1:0];
                        if (w_dic_sum <= 3'd3) begin
                            w_idle_nxt = c_IDLE_W'(MIN_IDLE_WORDS);
                        end else begin
                            w_idle_nxt = c_IDLE_W'(MIN_IDLE_WORDS + 1);
                        end
                    end
                end
                c_IPG: begin
                    w_idle_nxt = r_idle_cnt - c_IDLE_W'(1);
                    if (r_idle_cnt <= c_IDLE_W'(1)) begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pop0        = 1'b0;
        w_pop1        = 1'b0;
        w_tx_data     = c_IDLE_DATA;
        w_tx_ctrl     = 4'hF;
        w_set_under   = 1'b0;
        w_set_nostart = 1'b0;
        if (!w_slot) begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        w_pop0 = ~w_win1;
                        w_pop1 = w_win1;
                        if (w_is_start) begin
                            w_tx_data = w_gnt_q[31:0];
                            w_tx_ctrl = w_gnt_q[35:32];
                        end else begin
                            w_set_nostart = 1'b1;
                        end
                    end
                end
                c_SEND: begin
                    if (!w_own_empty) begin
                        w_pop0    = ~r_owner;
                        w_pop1    = r_owner;
                        w_tx_data = w_own_q[31:0];
                        w_tx_ctrl = w_own_q[35:32];
                    end else begin
                        w_tx_data   = c_ERR_DATA;
                        w_set_under = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ena_cnt      <= '0;
            r_idle_cnt     <= '0;
            r_dic          <= 2'd0;
            r_prio1        <= 1'b0;
            r_owner        <= 1'b0;
            r_grant        <= 2'b00;
            r_err_underrun <= 1'b0;
            r_err_nostart  <= 1'b0;
            r_tx           <= {c_IDLE_DATA, 4'hF, 1'b0};
        end else begin
            r_ena_cnt      <= w_slot ? '0 : r_ena_cnt + c_CNT_W'(1);
            r_idle_cnt     <= w_idle_nxt;
            r_dic          <= w_dic_nxt;
            r_prio1        <= w_prio_nxt;
            r_owner        <= w_owner_nxt;
            r_grant        <= w_grant_nxt;
            r_err_underrun <= w_set_under | (r_err_underrun & ~clr_err);
            r_err_nostart  <= w_set_nostart | (r_err_nostart & ~clr_err);
            r_tx           <= {w_tx_data, w_tx_ctrl, ~w_slot};
        end
    end

    // Pops are combinational, so they must also be held off while reset is asserted.
    assign src0_rdreq   = w_pop0 & ~rst;
    assign src1_rdreq   = w_pop1 & ~rst;
    assign tx           = r_tx;
    assign grant        = r_grant;
    assign err_underrun = r_err_underrun;
    assign err_nostart  = r_err_nostart;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_tx_frame_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_xgmii_tx_frame_arbiter: randomized bench with a frame-level stream model.
// Rev 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_xgmii_tx_frame_arbiter;
    import xgmii_tx_frame_arbiter_pkg::*;

    localparam int          P        = 33;
    localparam int          MIN_IDLE = 2;
    localparam logic [35:0] IDLE_W   = {4'hF, 32'h07070707};
    localparam logic [35:0] ERR_W    = {4'hF, 32'hFEFEFEFE};

    typedef struct { logic [39:0] w; int stall; } ent_t;
    typedef struct { logic [35:0] cd; bit start; logic [1:0] gnt; } exp_t;

    logic        clk;
    logic        rst = 1'b1;
    logic        clr_err = 1'b0;
    logic [39:0] src0_q = '0, src1_q = '0;
    logic        src0_empty = 1'b1, src1_empty = 1'b1;
    logic        src0_frame_rdy = 1'b0, src1_frame_rdy = 1'b0;
    logic        src0_rdreq, src1_rdreq;
    xgmii32_t    tx;
    logic [1:0]  grant;
    logic        err_underrun, err_nostart;

    ent_t        fifo0[$], fifo1[$], fw0[$], fw1[$];
    int          fl0[$], fl1[$];
    int          nfr0 = 0, nfr1 = 0;
    exp_t        expq[$];
    logic [35:0] obs[$];
    logic [1:0]  obs_g[$];
    int          n_checks = 0, n_errors = 0;
    int          tb_cnt = 0;
    bit          pend0 = 0, pend1 = 0;

    xgmii_tx_frame_arbiter #(.ENA_PERIOD(P), .MIN_IDLE_WORDS(MIN_IDLE)) dut (
        .clk(clk), .rst(rst),
        .src0_q(src0_q), .src0_empty(src0_empty), .src0_frame_rdy(src0_frame_rdy), .src0_rdreq(src0_rdreq),
        .src1_q(src1_q), .src1_empty(src1_empty), .src1_frame_rdy(src1_frame_rdy), .src1_rdreq(src1_rdreq),
        .tx(tx), .grant(grant), .err_underrun(err_underrun), .err_nostart(err_nostart), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_srcs();
        src0_q         = (fifo0.size() != 0) ? fifo0[0].w : 40'h0;
        src0_empty     = (fifo0.size() == 0) || (fifo0[0].stall > 0);
        src0_frame_rdy = (nfr0 > 0);
        src1_q         = (fifo1.size() != 0) ? fifo1[0].w : 40'h0;
        src1_empty     = (fifo1.size() == 0) || (fifo1[0].stall > 0);
        src1_frame_rdy = (nfr1 > 0);
    endtask

    // FIFO model and per-cycle output monitor, evaluated just after each edge.
    initial begin
        ent_t e;
        bit   ena_cyc;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                tb_cnt = 0;
                pend0  = 0;
                pend1  = 0;
            end else begin
                ena_cyc = (tb_cnt != P - 1);
                n_checks++;
                if (tx.ena !== ena_cyc) begin
                    n_errors++;
                    $display("FAIL ena_slot: tx.ena=%b required %b at count %0d", tx.ena, ena_cyc, tb_cnt);
                end
                if (tx.ena === 1'b0) begin
                    n_checks++;
                    if ({tx.ctrl, tx.data} !== IDLE_W) begin
                        n_errors++;
                        $display("FAIL slot_idle: ctrl/data=%h required %h", {tx.ctrl, tx.data}, IDLE_W);
                    end
                end else begin
                    obs.push_back({tx.ctrl, tx.data});
                    obs_g.push_back(grant);
                end
                if (pend0 && fifo0.size() != 0) begin
                    if (fifo0[0].w[36]) nfr0--;
                    void'(fifo0.pop_front());
                end else if (ena_cyc && fifo0.size() != 0 && fifo0[0].stall > 0) begin
                    e = fifo0[0]; e.stall--; fifo0[0] = e;
                end
                if (pend1 && fifo1.size() != 0) begin
                    if (fifo1[0].w[36]) nfr1--;
                    void'(fifo1.pop_front());
                end else if (ena_cyc && fifo1.size() != 0 && fifo1[0].stall > 0) begin
                    e = fifo1[0]; e.stall--; fifo1[0] = e;
                end
                tb_cnt = (tb_cnt == P - 1) ? 0 : tb_cnt + 1;
            end
            drive_srcs();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend0 = src0_rdreq;
                pend1 = src1_rdreq;
                n_checks++;
                if ((src0_rdreq && src0_empty) || (src1_rdreq && src1_empty) || (src0_rdreq && src1_rdreq) ||
                    ((tb_cnt == P - 1) && (src0_rdreq || src1_rdreq))) begin
                    n_errors++;
                    $display("FAIL rdreq_rules: rdreq0=%b rdreq1=%b empty0=%b empty1=%b count=%0d, required no illegal pop",
                             src0_rdreq, src1_rdreq, src0_empty, src1_empty, tb_cnt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_model();
        fifo0.delete(); fifo1.delete(); fw0.delete(); fw1.delete();
        fl0.delete(); fl1.delete(); expq.delete(); obs.delete(); obs_g.delete();
        nfr0 = 0; nfr1 = 0;
    endtask

    task automatic begin_test();
        rst     = 1'b1;
        clr_err = 1'b0;
        clear_model();
        step();
    endtask

    task automatic release_rst();
        step();
        rst = 1'b0;
    endtask

    task automatic add_frame(input int src, input int npay, input int sp, input int stall_at, input int stall_n);
        ent_t        e;
        logic [31:0] d;
        logic [1:0]  spv;
        logic [3:0]  c;
        int          n;
        n   = npay + 2;
        spv = 2'(sp);
        for (int k = 0; k < n; k++) begin
            d       = $urandom();
            e.stall = (k == stall_at && k > 0) ? stall_n : 0;
            if (k == 0) begin
                e.w = {1'b0, 2'b00, 1'b0, 4'b0001, d[31:8], 8'hFB};
            end else if (k < n - 1) begin
                e.w = {1'b0, 2'b00, 1'b0, 4'b0000, d};
            end else begin
                c = 4'hF << spv;
                for (int l = 0; l < 4; l++) begin
                    if (l == sp) d[8*l +: 8] = 8'hFD;
                    else if (l > sp) d[8*l +: 8] = 8'h07;
                end
                e.w = {1'b0, spv, 1'b1, c, d};
            end
            if (src == 0) begin fifo0.push_back(e); fw0.push_back(e); end
            else          begin fifo1.push_back(e); fw1.push_back(e); end
        end
        if (src == 0) begin fl0.push_back(n); nfr0++; end
        else          begin fl1.push_back(n); nfr1++; end
    endtask

    // Expected word stream: frames in round-robin order, each followed by its DIC gap.
    task automatic build_expected();
        int          i0, i1, w0, w1, dic, sp, gap, n;
        bit          p1, s, h0, h1;
        ent_t        e;
        exp_t        x;
        logic [39:0] last;
        i0 = 0; i1 = 0; w0 = 0; w1 = 0; dic = 0; p1 = 0;
        last = '0;
        expq.delete();
        while (i0 < fl0.size() || i1 < fl1.size()) begin
            h0 = (i0 < fl0.size());
            h1 = (i1 < fl1.size());
            s  = (h0 && h1) ? p1 : h1;
            p1 = !s;
            n  = s ? fl1[i1] : fl0[i0];
            for (int k = 0; k < n; k++) begin
                e = s ? fw1[w1 + k] : fw0[w0 + k];
                for (int j = 0; j < e.stall; j++) begin
                    x.cd = ERR_W; x.start = 0; x.gnt = 2'b00;
                    expq.push_back(x);
                end
                x.cd = e.w[35:0]; x.start = (k == 0); x.gnt = s ? 2'b10 : 2'b01;
                expq.push_back(x);
                last = e.w;
            end
            if (s) begin w1 += n; i1++; end else begin w0 += n; i0++; end
            sp = int'(last[38:37]);
            if (dic + sp <= 3) begin gap = MIN_IDLE;     dic = dic + sp;     end
            else               begin gap = MIN_IDLE + 1; dic = dic + sp - 4; end
            if (i0 < fl0.size() || i1 < fl1.size()) begin
                for (int j = 0; j < gap; j++) begin
                    x.cd = IDLE_W; x.start = 0; x.gnt = 2'b00;
                    expq.push_back(x);
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((fifo0.size() != 0 || fifo1.size() != 0) && cyc < 3000) begin
            step();
            cyc++;
        end
        n_checks++;
        if (fifo0.size() != 0 || fifo1.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: %0d/%0d words left after %0d cycles, required 0/0", name, fifo0.size(), fifo1.size(), cyc);
        end
        repeat (6) step();
    endtask

    task automatic compare_stream(input string name);
        int i;
        int bad;
        i = 0;
        build_expected();
        while (i < obs.size() && obs[i] == IDLE_W) i++;
        for (int k = 0; k < expq.size(); k++) begin
            n_checks++;
            if (i + k >= obs.size()) begin
                n_errors++;
                $display("FAIL %s_short: got %0d words, required %0d", name, obs.size() - i, expq.size());
                break;
            end
            if (obs[i + k] !== expq[k].cd) begin
                n_errors++;
                $display("FAIL %s_word[%0d]: ctrl/data=%h required %h", name, k, obs[i + k], expq[k].cd);
                break;
            end
            if (expq[k].start) begin
                n_checks++;
                if (obs_g[i + k] !== expq[k].gnt) begin
                    n_errors++;
                    $display("FAIL %s_grant[%0d]: grant=%b required %b", name, k, obs_g[i + k], expq[k].gnt);
                end
            end
        end
        bad = 0;
        for (int k = i + expq.size(); k < obs.size(); k++) if (obs[k] !== IDLE_W) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s_tail: %0d non-idle words after last frame, required 0", name, bad);
        end
    endtask

    task automatic check_flags(input string name, input logic exp_u, input logic exp_n);
        n_checks++;
        if (err_underrun !== exp_u || err_nostart !== exp_n) begin
            n_errors++;
            $display("FAIL %s_flags: underrun=%b nostart=%b required %b %b", name, err_underrun, err_nostart, exp_u, exp_n);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({tx.data, tx.ctrl, tx.ena} !== {32'h07070707, 4'hF, 1'b0} || src0_rdreq !== 1'b0 ||
            src1_rdreq !== 1'b0 || grant !== 2'b00) begin
            n_errors++;
            $display("FAIL %s: tx=%h/%h/%b rdreq=%b%b grant=%b required 07070707/f/0 00 00",
                     name, tx.data, tx.ctrl, tx.ena, src1_rdreq, src0_rdreq, grant);
        end
    endtask

    task automatic test_reset();
        begin_test();
        #1;
        check_reset_outputs("reset_state");
        check_flags("reset", 1'b0, 1'b0);
    endtask

    task automatic test_single_frame();
        begin_test();
        add_frame(0, 2, 2, 0, 0);
        add_frame(0, 1, int'($urandom_range(0, 3)), 0, 0);
        release_rst();
        wait_drain("single");
        compare_stream("single");
        check_flags("single", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        begin_test();
        add_frame(0, 3, 2, 0, 0);
        add_frame(0, 2, 2, 0, 0);
        add_frame(0, 1, 0, 0, 0);
        release_rst();
        wait_drain("b2b");
        compare_stream("b2b");
    endtask

    task automatic test_round_robin();
        begin_test();
        for (int k = 0; k < 3; k++) begin
            add_frame(0, 1, int'($urandom_range(0, 3)), 0, 0);
            add_frame(1, 1, int'($urandom_range(0, 3)), 0, 0);
        end
        release_rst();
        wait_drain("rr");
        compare_stream("rr");
    endtask

    task automatic test_ena_slot();
        begin_test();
        add_frame(0, 40, 3, 0, 0);
        add_frame(1, 40, 1, 0, 0);
        add_frame(0, 30, 2, 0, 0);
        release_rst();
        wait_drain("slot");
        compare_stream("slot");
    endtask

    task automatic test_underrun();
        begin_test();
        add_frame(0, 3, 1, 2, 2);
        add_frame(0, 1, 0, 0, 0);
        release_rst();
        wait_drain("underrun");
        compare_stream("underrun");
        check_flags("underrun_set", 1'b1, 1'b0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_flags("underrun_clr", 1'b0, 1'b0);
    endtask

    task automatic test_nostart();
        ent_t        e;
        logic [31:0] d;
        begin_test();
        d = $urandom();
        e.w = {1'b0, 2'b00, 1'b0, 4'b0000, d};
        e.stall = 0;
        fifo0.push_back(e);
        add_frame(0, 2, 3, 0, 0);
        step();
        // clr_err coincides with the bad-head grant; the new error must win.
        rst     = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        wait_drain("nostart");
        compare_stream("nostart");
        check_flags("nostart", 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_send();
        begin_test();
        add_frame(0, 1, 3, 0, 0);
        add_frame(0, 20, 1, 0, 0);
        release_rst();
        repeat (10) step();
        n_checks++;
        if (grant !== 2'b01) begin
            n_errors++;
            $display("FAIL mid_send_grant: grant=%b required 01", grant);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_send_reset");
        clear_model();
        add_frame(0, 1, 2, 0, 0);
        add_frame(0, 2, 2, 0, 0);
        add_frame(0, 1, 1, 0, 0);
        step();
        release_rst();
        wait_drain("after_reset");
        compare_stream("after_reset");
    endtask

    task automatic test_random();
        int  na, nb, st_at, st_n, np;
        logic any_stall;
        begin_test();
        any_stall = 1'b0;
        na = int'($urandom_range(4, 8));
        nb = int'($urandom_range(4, 8));
        for (int k = 0; k < na + nb; k++) begin
            np    = int'($urandom_range(0, 6));
            st_at = 0;
            st_n  = 0;
            if ($urandom_range(0, 3) == 0) begin
                st_at = int'($urandom_range(1, np + 1));
                st_n  = int'($urandom_range(1, 3));
                any_stall = 1'b1;
            end
            add_frame((k < na) ? 0 : 1, np, int'($urandom_range(0, 3)), st_at, st_n);
        end
        release_rst();
        wait_drain("random");
        compare_stream("random");
        check_flags("random", any_stall, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_round_robin();
        test_ena_slot();
        test_underrun();
        test_nostart();
        test_reset_mid_send();
        for (int r = 0; r < 3; r++) test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
